pc_sel_ctrl: RTL and testbench

Next-PC control unit that drives the fetch stage's PC source select and its flush (should_br) signal.
- Sequences the boot cycles after reset.
- Applies EX-stage redirects (taken branch / JALR via ALU_result) and IF-detected JAL (jump_addr).
- Holds the PC during stalls; a redirect raised during a stall is remembered until the stall clears.
- Keeps a saturating flush counter for the CSR/debug path.

---
 rtl/pc_sel_ctrl.sv | 115 +++++++++++
 tb/tb_pc_sel_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sel_ctrl.sv
// Next-PC control for the fetch stage: boot sequencing, EX redirects, IF-detected JAL,
// stall hold with a remembered redirect, and a saturating count of squash cycles.
module pc_sel_ctrl #(
   parameter int unsigned BOOT_CYCLES = 2,
   parameter logic [6:0]  OPC_JAL     = 7'b1101111
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        ex_redirect,
   input  logic [6:0]  if_opcode,
   output logic [2:0]  PC_sel,
   output logic        should_br,
   output logic        booting,
   output logic [31:0] flush_count
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   localparam logic [3:0]  BOOT_LAST = 4'(BOOT_CYCLES - 1);
   localparam logic [2:0]  SEL_RESET = 3'd0;
   localparam logic [2:0]  SEL_HOLD  = 3'd1;
   localparam logic [2:0]  SEL_SEQ   = 3'd2;
   localparam logic [2:0]  SEL_ALU   = 3'd3;
   localparam logic [2:0]  SEL_JAL   = 3'd4;
   localparam logic [31:0] FLUSH_MAX = 32'hFFFF_FFFF;

   state_t      r_state;
   state_t      w_nextState;
   logic [3:0]  r_bootCnt;
   logic [31:0] r_flushCount;
   logic [2:0]  w_sel;
   logic        w_br;

   // The unused encoding falls through to the defaults and therefore returns to BOOT.
   always_comb begin
      w_nextState = ST_BOOT;
      w_sel       = SEL_RESET;
      w_br        = 1'b0;
      case (r_state)
         ST_BOOT: begin
            w_br        = 1'b1;
            w_nextState = (r_bootCnt == 4'd0) ? ST_RUN : ST_BOOT;
         end
         ST_RUN: begin
            w_nextState = ST_RUN;
            if (ex_redirect && !stall) begin
               w_sel = SEL_ALU;
               w_br  = 1'b1;
            end else if (ex_redirect) begin
               w_sel       = SEL_HOLD;
               w_br        = 1'b1;
               w_nextState = ST_PEND;
            end else if (stall) begin
               w_sel = SEL_HOLD;
            end else if (if_opcode == OPC_JAL) begin
               w_sel = SEL_JAL;
            end else begin
               w_sel = SEL_SEQ;
            end
         end
         ST_PEND: begin
            w_br = 1'b1;
            if (stall) begin
               w_sel       = SEL_HOLD;
               w_nextState = ST_PEND;
            end else begin
               w_sel       = SEL_ALU;
               w_nextState = ST_RUN;
            end
         end
         default: begin
            w_nextState = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_BOOT;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Counter is reloaded whenever we are outside BOOT, so any later entry starts full.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bootCnt <= BOOT_LAST;
      end else if (r_state != ST_BOOT) begin
         r_bootCnt <= BOOT_LAST;
      end else if (r_bootCnt != 4'd0) begin
         r_bootCnt <= r_bootCnt - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_flushCount <= 32'd0;
      end else if (w_br && (r_flushCount != FLUSH_MAX)) begin
         r_flushCount <= r_flushCount + 32'd1;
      end
   end

   // BOOT asserts a squash, but reset itself must present should_br low.
   assign PC_sel      = w_sel;
   assign should_br   = w_br & rst;
   assign booting     = (r_state == ST_BOOT);
   assign flush_count = r_flushCount;

endmodule

// File: tb/tb_pc_sel_ctrl.sv
// Bench for pc_sel_ctrl: directed scenarios plus a random run, all checked against
// a small behavioural model of boot time left, pending redirect and flush total.
module tb_pc_sel_ctrl;

   localparam int unsigned BOOT_CYCLES = 2;
   localparam logic [6:0]  OPC_JAL     = 7'b1101111;
   localparam logic [6:0]  OPC_ADDI    = 7'b0010011;
   localparam logic [31:0] FLUSH_MAX   = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        ex_redirect = 1'b0;
   logic [6:0]  if_opcode = OPC_ADDI;
   logic [2:0]  PC_sel;
   logic        should_br;
   logic        booting;
   logic [31:0] flush_count;

   int nChecks = 0;
   int nPass   = 0;

   int          bootLeft;
   bit          pending;
   logic [31:0] mFlush;
   logic [2:0]  expSel;
   logic        expBr;
   logic        expBoot;

   pc_sel_ctrl #(
      .BOOT_CYCLES(BOOT_CYCLES),
      .OPC_JAL    (OPC_JAL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .ex_redirect(ex_redirect),
      .if_opcode  (if_opcode),
      .PC_sel     (PC_sel),
      .should_br  (should_br),
      .booting    (booting),
      .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   // Reference: what fetch should do this cycle given remaining boot time and a held redirect.
   task automatic predict();
      if (!rst) begin
         bootLeft = BOOT_CYCLES;
         pending  = 1'b0;
         mFlush   = 32'd0;
         expSel   = 3'd0;
         expBr    = 1'b0;
         expBoot  = 1'b1;
      end else if (bootLeft > 0) begin
         expSel  = 3'd0;
         expBr   = 1'b1;
         expBoot = 1'b1;
      end else begin
         expBoot = 1'b0;
         if (pending) begin
            expBr  = 1'b1;
            expSel = stall ? 3'd1 : 3'd3;
         end else if (ex_redirect) begin
            expBr  = 1'b1;
            expSel = stall ? 3'd1 : 3'd3;
         end else begin
            expBr  = 1'b0;
            expSel = stall ? 3'd1 : ((if_opcode == OPC_JAL) ? 3'd4 : 3'd2);
         end
      end
   endtask

   task automatic applyStimulus(input logic st, input logic rd, input logic [6:0] op);
      stall       = st;
      ex_redirect = rd;
      if_opcode   = op;
   endtask

   // Clock edge: the model absorbs the cycle just presented, then returns at posedge+1.
   task automatic advance();
      predict();
      @(posedge clk);
      if (rst) begin
         if (expBr && (mFlush != FLUSH_MAX)) mFlush = mFlush + 32'd1;
         if (bootLeft > 0) bootLeft--;
         else if (pending && !stall) pending = 1'b0;
         else if (!pending && ex_redirect && stall) pending = 1'b1;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, OPC_ADDI);
      for (int c = 0; c < 3; c++) begin
         #4;
         predict();
         nChecks++;
         if ({PC_sel, should_br, booting, flush_count} !== {expSel, expBr, expBoot, mFlush})
            $display("[TB] FAIL reset[%0d]: got sel=%0d br=%0b boot=%0b fc=%h, expected sel=%0d br=%0b boot=%0b fc=%h",
                     c, PC_sel, should_br, booting, flush_count, expSel, expBr, expBoot, mFlush);
         else nPass++;
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b0, 1'b0, OPC_ADDI);
         #4;
         predict();
         nChecks++;
         if ({PC_sel, should_br, booting, flush_count} !== {expSel, expBr, expBoot, mFlush})
            $display("[TB] FAIL boot[%0d]: got sel=%0d br=%0b boot=%0b fc=%h, expected sel=%0d br=%0b boot=%0b fc=%h",
                     c, PC_sel, should_br, booting, flush_count, expSel, expBr, expBoot, mFlush);
         else nPass++;
         advance();
      end
      nChecks++;
      if (flush_count !== 32'd2)
         $display("[TB] FAIL boot_flush_total: got fc=%0d, expected fc=2", flush_count);
      else nPass++;
   endtask

   task automatic test_seq_jal_redirect();
      logic       st[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic       rd[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [6:0] op[5] = '{OPC_ADDI, OPC_JAL, OPC_JAL, OPC_JAL, OPC_JAL};
      for (int c = 0; c < 5; c++) begin
         applyStimulus(st[c], rd[c], op[c]);
         #4;
         predict();
         nChecks++;
         if ({PC_sel, should_br, booting, flush_count} !== {expSel, expBr, expBoot, mFlush})
            $display("[TB] FAIL seq_jal_redirect[%0d]: got sel=%0d br=%0b boot=%0b fc=%h, expected sel=%0d br=%0b boot=%0b fc=%h",
                     c, PC_sel, should_br, booting, flush_count, expSel, expBr, expBoot, mFlush);
         else nPass++;
         advance();
      end
   endtask

   task automatic test_redirect_stall();
      logic        st[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic        rd[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [31:0] startFlush;
      startFlush = flush_count;
      for (int c = 0; c < 7; c++) begin
         applyStimulus(st[c], rd[c], OPC_JAL);
         #4;
         predict();
         nChecks++;
         if ({PC_sel, should_br, booting, flush_count} !== {expSel, expBr, expBoot, mFlush})
            $display("[TB] FAIL redirect_stall[%0d]: got sel=%0d br=%0b boot=%0b fc=%h, expected sel=%0d br=%0b boot=%0b fc=%h",
                     c, PC_sel, should_br, booting, flush_count, expSel, expBr, expBoot, mFlush);
         else nPass++;
         advance();
      end
      nChecks++;
      if (flush_count !== startFlush + 32'd5)
         $display("[TB] FAIL redirect_stall_total: got fc=%0d, expected fc=%0d", flush_count, startFlush + 32'd5);
      else nPass++;
   endtask

   task automatic test_async_reset();
      applyStimulus(1'b1, 1'b1, OPC_ADDI);
      advance();
      applyStimulus(1'b1, 1'b0, OPC_ADDI);
      advance();
      #2;
      rst = 1'b0;
      #1;
      predict();
      nChecks++;
      if ({PC_sel, should_br, booting, flush_count} !== {expSel, expBr, expBoot, mFlush})
         $display("[TB] FAIL async_reset_now: got sel=%0d br=%0b boot=%0b fc=%h, expected sel=%0d br=%0b boot=%0b fc=%h",
                  PC_sel, should_br, booting, flush_count, expSel, expBr, expBoot, mFlush);
      else nPass++;
      @(posedge clk);
      #1;
      advance();
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b0, 1'b0, OPC_ADDI);
         #4;
         predict();
         nChecks++;
         if ({PC_sel, should_br, booting, flush_count} !== {expSel, expBr, expBoot, mFlush})
            $display("[TB] FAIL async_reboot[%0d]: got sel=%0d br=%0b boot=%0b fc=%h, expected sel=%0d br=%0b boot=%0b fc=%h",
                     c, PC_sel, should_br, booting, flush_count, expSel, expBr, expBoot, mFlush);
         else nPass++;
         advance();
      end
   endtask

   task automatic test_saturation();
      #2;
      force dut.r_flushCount = 32'hFFFF_FFFD;
      #1;
      release dut.r_flushCount;
      mFlush = 32'hFFFF_FFFD;
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b0, 1'b1, OPC_ADDI);
         #1;
         predict();
         nChecks++;
         if ({PC_sel, should_br, booting, flush_count} !== {expSel, expBr, expBoot, mFlush})
            $display("[TB] FAIL saturation[%0d]: got sel=%0d br=%0b boot=%0b fc=%h, expected sel=%0d br=%0b boot=%0b fc=%h",
                     c, PC_sel, should_br, booting, flush_count, expSel, expBr, expBoot, mFlush);
         else nPass++;
         advance();
         #3;
      end
      nChecks++;
      if (flush_count !== FLUSH_MAX)
         $display("[TB] FAIL saturation_final: got fc=%h, expected fc=%h", flush_count, FLUSH_MAX);
      else nPass++;
   endtask

   task automatic test_random();
      logic [6:0] op;
      for (int c = 0; c < 400; c++) begin
         op = ($urandom_range(0, 2) == 0) ? OPC_JAL : 7'($urandom);
         applyStimulus(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), op);
         #4;
         predict();
         nChecks++;
         if ({PC_sel, should_br, booting, flush_count} !== {expSel, expBr, expBoot, mFlush})
            $display("[TB] FAIL random[%0d]: got sel=%0d br=%0b boot=%0b fc=%h, expected sel=%0d br=%0b boot=%0b fc=%h",
                     c, PC_sel, should_br, booting, flush_count, expSel, expBr, expBoot, mFlush);
         else nPass++;
         advance();
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_seq_jal_redirect();
      test_redirect_stall();
      test_async_reset();
      test_random();
      test_saturation();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
